// File: rtl/digit_entry_pkg.sv
// Shared types and sizes for the six-digit entry controller.
package digit_entry_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int CNT_W      = 3;
    localparam int DIGIT_W    = 4;

    typedef enum logic [1:0] {
        ENTRY,
        FULL,
        SCROLL
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer and debouncer for an active-low key.
// Emits a one-cycle pulse when the debounced level falls.
module key_debounce #(
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;
    logic          settle;

    // The pulse is raised in the cycle before the level flips, so the consumer
    // acts on the same edge that commits the new level.
    assign settle = (sync2 != level) && (count == CW'(DEBOUNCE - 1));
    assign press  = settle && level;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            count <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                count <= '0;
            end else if (settle) begin
                level <= ~level;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Loads six digits one at a time from a debounced key, then optionally
// rotates them left on a slow clock-enable tick.
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_n,
    input  logic [DIGIT_W-1:0] data,
    input  logic               clear,
    input  logic               scroll_en,
    output logic [DIGIT_W-1:0] out0,
    output logic [DIGIT_W-1:0] out1,
    output logic [DIGIT_W-1:0] out2,
    output logic [DIGIT_W-1:0] out3,
    output logic [DIGIT_W-1:0] out4,
    output logic [DIGIT_W-1:0] out5,
    output logic [CNT_W-1:0]   cnt,
    output logic               full
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic               load_evt;
    logic               clear_s1, clear_s2;
    logic               scroll_s1, scroll_s2;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [DIGIT_W-1:0] digits [NUM_DIGITS];
    logic [CNT_W-1:0]   count;
    logic               full_q;
    state_t             state;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_load_key (
        .clock (clock),
        .reset (reset),
        .key_n (load_n),
        .press (load_evt)
    );

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clear_s1  <= 1'b0;
            clear_s2  <= 1'b0;
            scroll_s1 <= 1'b0;
            scroll_s2 <= 1'b0;
            tick_cnt  <= '0;
        end else begin
            clear_s1  <= clear;
            clear_s2  <= clear_s1;
            scroll_s1 <= scroll_en;
            scroll_s2 <= scroll_s1;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Priority: clear, then load, then tick rotation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
            count  <= '0;
            full_q <= 1'b0;
            state  <= ENTRY;
        end else if (clear_s2) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
            count  <= '0;
            full_q <= 1'b0;
            state  <= ENTRY;
        end else begin
            case (state)
                ENTRY: begin
                    if (load_evt) begin
                        // First digit lands in the leftmost position.
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (CNT_W'(NUM_DIGITS - 1 - i) == count) digits[i] <= data;
                        end
                        count <= count + 1'b1;
                        if (count == CNT_W'(NUM_DIGITS - 1)) begin
                            full_q <= 1'b1;
                            state  <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (scroll_s2) state <= SCROLL;
                end
                SCROLL: begin
                    if (!scroll_s2) begin
                        state <= FULL;
                    end else if (tick) begin
                        digits[0] <= digits[NUM_DIGITS-1];
                        for (int i = 1; i < NUM_DIGITS; i++) digits[i] <= digits[i-1];
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

    assign out0 = digits[0];
    assign out1 = digits[1];
    assign out2 = digits[2];
    assign out3 = digits[3];
    assign out4 = digits[4];
    assign out5 = digits[5];
    assign cnt  = count;
    assign full = full_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl: vector table for entry/clear, plus
// hand sequences for async reset, scrolling, clear priority and key bounce.
module tb_digit_entry_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       load_n    = 1'b1;
    logic       clear     = 1'b0;
    logic       scroll_en = 1'b0;
    logic [3:0] data      = 4'h0;
    logic [3:0] out0, out1, out2, out3, out4, out5;
    logic [2:0] cnt;
    logic       full;
    logic [23:0] disp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_clear;
        logic [3:0]  data;
        logic [23:0] exp_d;
        logic [2:0]  exp_c;
        logic        exp_f;
    } vec_t;

    vec_t vecs [11];

    always #5 clock = ~clock;

    digit_entry_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_n    (load_n),
        .data      (data),
        .clear     (clear),
        .scroll_en (scroll_en),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .cnt       (cnt),
        .full      (full)
    );

    assign disp = {out5, out4, out3, out2, out1, out0};

    function automatic logic [23:0] rot(input logic [23:0] d);
        return {d[19:0], d[23:20]};
    endfunction

    task automatic check(input string name, input logic [23:0] ed, input logic [2:0] ec,
                         input logic ef);
        checks++;
        if ({disp, cnt, full} !== {ed, ec, ef}) begin
            failures++;
            $display("FAIL %s: got digits=%h cnt=%0d full=%b, want digits=%h cnt=%0d full=%b",
                     name, disp, cnt, full, ed, ec, ef);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] d);
        data   = d;
        load_n = 1'b0;
        cycles(8);
        load_n = 1'b1;
        cycles(8);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        cycles(4);
        clear = 1'b0;
        cycles(4);
    endtask

    task automatic run_vec(input int i);
        if (vecs[i].is_clear) clear_pulse();
        else press(vecs[i].data);
        check($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_f);
    endtask

    // Waits (bounded) for the display to move away from cur.
    task automatic wait_rotation(input string name, input logic [23:0] cur);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clock);
            if (disp !== cur) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: digits stayed %h for 24 cycles, want a rotation to %h",
                     name, disp, rot(cur));
        end
    endtask

    initial begin
        logic [23:0] exp;

        vecs[0]  = '{1'b0, 4'h1, 24'h100000, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 4'h2, 24'h120000, 3'd2, 1'b0};
        vecs[2]  = '{1'b0, 4'h3, 24'h123000, 3'd3, 1'b0};
        vecs[3]  = '{1'b0, 4'h4, 24'h123400, 3'd4, 1'b0};
        vecs[4]  = '{1'b0, 4'h5, 24'h123450, 3'd5, 1'b0};
        vecs[5]  = '{1'b0, 4'h6, 24'h123456, 3'd6, 1'b1};
        vecs[6]  = '{1'b0, 4'h9, 24'h123456, 3'd6, 1'b1};
        vecs[7]  = '{1'b0, 4'h4, 24'h400000, 3'd1, 1'b0};
        vecs[8]  = '{1'b0, 4'h8, 24'h480000, 3'd2, 1'b0};
        vecs[9]  = '{1'b1, 4'h0, 24'h000000, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 4'h5, 24'h500000, 3'd1, 1'b0};

        // Reset, then asynchronous reset in the middle of entry.
        cycles(3);
        check("reset_state", 24'h0, 3'd0, 1'b0);
        reset = 1'b1;
        cycles(2);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        check("pre_async_reset", 24'h123000, 3'd3, 1'b0);
        #2 reset = 1'b0;
        #1 check("async_reset", 24'h0, 3'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        cycles(2);
        press(4'h7);
        check("after_reset_load", 24'h700000, 3'd1, 1'b0);
        clear_pulse();
        check("clear_to_empty", 24'h0, 3'd0, 1'b0);

        // Full entry and an ignored seventh press.
        for (int i = 0; i <= 6; i++) run_vec(i);

        // Scroll: rotate every TICK_DIV cycles, wrap after six, freeze on disable.
        exp = 24'h123456;
        scroll_en = 1'b1;
        wait_rotation("scroll_start", exp);
        exp = rot(exp);
        check("scroll_tick1", exp, 3'd6, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            cycles(3);
            check($sformatf("scroll_hold%0d", k), exp, 3'd6, 1'b1);
            cycles(1);
            exp = rot(exp);
            check($sformatf("scroll_tick%0d", k), exp, 3'd6, 1'b1);
            if (k == 6) check("scroll_wrap", 24'h123456, 3'd6, 1'b1);
        end
        scroll_en = 1'b0;
        cycles(12);
        check("scroll_freeze", 24'h345612, 3'd6, 1'b1);

        // Clear, load_evt and tick all land on edge R+8.
        scroll_en = 1'b1;
        exp = 24'h345612;
        wait_rotation("rescroll_start", exp);
        exp = rot(exp);
        cycles(3);
        data   = 4'hF;
        load_n = 1'b0;
        cycles(2);
        clear = 1'b1;
        cycles(2);
        exp = rot(exp);
        check("pre_clear", exp, 3'd6, 1'b1);
        cycles(1);
        check("clear_priority", 24'h0, 3'd0, 1'b0);
        load_n    = 1'b1;
        scroll_en = 1'b0;
        cycles(8);
        check("clear_hold", 24'h0, 3'd0, 1'b0);
        clear = 1'b0;
        cycles(4);

        // Partial entry, clear, reload.
        for (int i = 7; i <= 10; i++) run_vec(i);

        // Bounce: a 2-cycle glitch is dropped; a real press writes on edge 5.
        data   = 4'hA;
        load_n = 1'b0;
        cycles(2);
        load_n = 1'b1;
        cycles(10);
        check("glitch_ignored", 24'h500000, 3'd1, 1'b0);
        data   = 4'hB;
        load_n = 1'b0;
        cycles(4);
        check("press_edge4", 24'h500000, 3'd1, 1'b0);
        cycles(1);
        check("press_edge5", 24'h5B0000, 3'd2, 1'b0);
        cycles(5);
        load_n = 1'b1;
        cycles(10);
        check("release_no_event", 24'h5B0000, 3'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
